// File: rtl/down_counter_4bit.sv
// Loadable down counter with IDLE/RUN/DONE timer FSM and borrow out.
// Define DOWN_COUNTER_AUTORELOAD_EN to restart from the last loaded value.
module down_counter_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_zero;
  logic             w_one;

  assign w_zero = (r_count == '0);
  assign w_one  = (r_count == WIDTH'(1));

`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reload <= '0;
    end else if (load) begin
      r_reload <= in;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (load) begin
      w_count_nxt = in;
    end else if (en) begin
      w_count_nxt = r_count - WIDTH'(1);
    end
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // a load this cycle restarts the timer, so skip terminal check
        if (!load && (w_zero || (en && w_one))) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        w_state_nxt = S_RUN;
        if (!load) begin
          w_count_nxt = r_reload;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign count = r_count;
  assign bo    = en & ~load & w_zero;
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_down_counter_4bit.sv
// Directed bench for down_counter_4bit.
// Build with DOWN_COUNTER_AUTORELOAD_EN to cover the autoreload variant.
module tb_down_counter_4bit;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] t_in;
  logic       start;
  logic [3:0] count;
  logic       bo;
  logic       busy;
  logic       done;

  int n_err;
  int n_chk;

  down_counter_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .in    (t_in),
    .start (start),
    .count (count),
    .bo    (bo),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic state_chk(input string tag,
                           input logic [3:0] c,
                           input logic b,
                           input logic d);
    chk({tag, "_count"}, {4'h0, count}, {4'h0, c});
    chk({tag, "_busy"}, {7'h0, busy}, {7'h0, b});
    chk({tag, "_done"}, {7'h0, done}, {7'h0, d});
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    rst   = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    t_in  = 4'h0;
    #2;
    state_chk("rst0", 4'h0, 1'b0, 1'b0);
    chk("rst0_bo", {7'h0, bo}, 8'h0);
    rst = 1'b1;

    // wrap and borrow from zero in IDLE
    step();
    en = 1'b1;
    #1;
    chk("wrap_bo1", {7'h0, bo}, 8'h1);
    step();
    state_chk("wrap", 4'hF, 1'b0, 1'b0);
    chk("wrap_bo0", {7'h0, bo}, 8'h0);

    // load beats enable
    en   = 1'b0;
    load = 1'b1;
    t_in = 4'h5;
    step();
    chk("ld5", {4'h0, count}, 8'h5);
    en   = 1'b1;
    t_in = 4'hA;
    step();
    chk("prio", {4'h0, count}, 8'hA);
    t_in = 4'h0;
    step();
    chk("ld0", {4'h0, count}, 8'h0);
    chk("bo_ld", {7'h0, bo}, 8'h0);
    load = 1'b0;
    #1;
    chk("bo_en", {7'h0, bo}, 8'h1);
    en = 1'b0;

    // async reset while running
    load  = 1'b1;
    start = 1'b1;
    t_in  = 4'h9;
    step();
    state_chk("run9", 4'h9, 1'b1, 1'b0);
    load  = 1'b0;
    start = 1'b0;
    rst   = 1'b0;
    #1;
    state_chk("arst", 4'h0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    state_chk("arst_idle", 4'h0, 1'b0, 1'b0);

    // timer: load 3 with start, en held
    load  = 1'b1;
    start = 1'b1;
    en    = 1'b1;
    t_in  = 4'h3;
    step();
    state_chk("tm3", 4'h3, 1'b1, 1'b0);
    load  = 1'b0;
    start = 1'b0;
    step();
    state_chk("tm2", 4'h2, 1'b1, 1'b0);
    step();
    state_chk("tm1", 4'h1, 1'b1, 1'b0);
    step();
    state_chk("tm0", 4'h0, 1'b0, 1'b1);
    step();
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    state_chk("tm_after", 4'h3, 1'b1, 1'b0);
`else
    state_chk("tm_after", 4'hF, 1'b0, 1'b0);
`endif

    // reload while running suppresses done
    en = 1'b0;
    pulse_rst();
    load  = 1'b1;
    start = 1'b1;
    t_in  = 4'h1;
    step();
    state_chk("rl1", 4'h1, 1'b1, 1'b0);
    start = 1'b0;
    en    = 1'b1;
    t_in  = 4'h6;
    step();
    state_chk("rl6", 4'h6, 1'b1, 1'b0);
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      state_chk($sformatf("rl_dec%0d", i),
                4'(5 - i),
                (i != 5),
                (i == 5));
    end

    // zero loaded before start, en low
    en = 1'b0;
    pulse_rst();
    load  = 1'b1;
    start = 1'b1;
    t_in  = 4'h0;
    step();
    state_chk("z_run", 4'h0, 1'b1, 1'b0);
    load  = 1'b0;
    start = 1'b0;
    step();
    state_chk("z_done", 4'h0, 1'b0, 1'b1);
    start = 1'b1;
    step();
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    state_chk("z_after", 4'h0, 1'b1, 1'b0);
`else
    state_chk("z_after", 4'h0, 1'b0, 1'b0);
    step();
    state_chk("z_start", 4'h0, 1'b1, 1'b0);
`endif
    start = 1'b0;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    // autoreload: period of three cycles
    pulse_rst();
    load  = 1'b1;
    start = 1'b1;
    en    = 1'b1;
    t_in  = 4'h2;
    step();
    state_chk("ar0", 4'h2, 1'b1, 1'b0);
    load  = 1'b0;
    start = 1'b0;
    step();
    state_chk("ar1", 4'h1, 1'b1, 1'b0);
    step();
    state_chk("ar2", 4'h0, 1'b0, 1'b1);
    step();
    state_chk("ar3", 4'h2, 1'b1, 1'b0);
    step();
    state_chk("ar4", 4'h1, 1'b1, 1'b0);
    step();
    state_chk("ar5", 4'h0, 1'b0, 1'b1);
    load = 1'b1;
    t_in = 4'h7;
    step();
    state_chk("ar_ld", 4'h7, 1'b1, 1'b0);
    load = 1'b0;
    en   = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
